// File: rtl/dac_wave_pkg.sv
// Shared constants for the DAC waveform sequencer: mode codes, FSM states and code width.
package dac_wave_pkg;

  localparam int DAC_W = 8;

  localparam logic [1:0] MODE_HOLD = 2'd0;
  localparam logic [1:0] MODE_SAW  = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_SQR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/dac_wave_seq_tick_gen.sv
// Sample-rate prescaler: one-cycle tick every TICK_DIV cycles while enabled.
module tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;

  assign tick = en && (tick_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (!en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dac_wave_seq.sv
// Waveform sequencer driving the DAC code / 7-seg value with hold, sawtooth,
// triangle and square sequences stepped by a programmable sample tick.
module dac_wave_seq
  import dac_wave_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [DAC_W-1:0] step,
  input  logic [DAC_W-1:0] top,
  output logic [DAC_W-1:0] dac_val,
  output logic             dac_we,
  output logic             busy
);

  state_t           state;
  logic [1:0]       cfg_mode;
  logic [DAC_W-1:0] cfg_step;
  logic [DAC_W-1:0] cfg_top;
  logic             tick;
  logic [DAC_W:0]   sum;

  // Zero step would stall the ramp, so it is promoted to one when latched.
  function automatic logic [DAC_W-1:0] eff_step(input logic [DAC_W-1:0] s);
    return (s == '0) ? DAC_W'(1) : s;
  endfunction

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .tick (tick)
  );

  // One bit of headroom so the ramp never wraps past 255.
  assign sum = {1'b0, dac_val} + {1'b0, cfg_step};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dac_val  <= '0;
      dac_we   <= 1'b0;
      busy     <= 1'b0;
      cfg_mode <= MODE_HOLD;
      cfg_step <= DAC_W'(1);
      cfg_top  <= '0;
    end else begin
      dac_we <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              cfg_mode <= mode;
              cfg_step <= eff_step(step);
              cfg_top  <= top;
              dac_we   <= 1'b1;
              if (mode == MODE_HOLD) begin
                dac_val <= top;
              end else begin
                dac_val <= '0;
                state   <= ST_UP;
                busy    <= 1'b1;
              end
            end
          end
          ST_UP: begin
            if (tick) begin
              dac_we <= 1'b1;
              case (cfg_mode)
                MODE_SAW: begin
                  if (sum > {1'b0, cfg_top}) dac_val <= '0;
                  else                       dac_val <= sum[DAC_W-1:0];
                end
                MODE_TRI: begin
                  if (sum >= {1'b0, cfg_top}) begin
                    dac_val <= cfg_top;
                    state   <= ST_DOWN;
                  end else begin
                    dac_val <= sum[DAC_W-1:0];
                  end
                end
                MODE_SQR: begin
                  dac_val <= cfg_top;
                  state   <= ST_DOWN;
                end
                default: dac_val <= dac_val;
              endcase
            end
          end
          ST_DOWN: begin
            if (tick) begin
              dac_we <= 1'b1;
              if (cfg_mode == MODE_TRI && dac_val > cfg_step) begin
                dac_val <= dac_val - cfg_step;
              end else begin
                dac_val <= '0;
                state   <= ST_UP;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
